// File: rtl/ball_motion_ctrl.sv
// Frame-rate ball sequencer: serve/move/pause control,
// ball position, direction and wall bounce pulses.
module ball_motion_ctrl #(
  parameter int H_MAX        = 640,
  parameter int V_MAX        = 480,
  parameter int BALL_SIZE    = 4,
  parameter int H_INIT       = 64,
  parameter int V_INIT       = 64,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       launch,
  output logic [9:0] ball_hpos,
  output logic [9:0] ball_vpos,
  output logic       hit_h,
  output logic       hit_v,
  output logic [1:0] state
);

  localparam int CW =
    (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [9:0] H_LIM = 10'(H_MAX - BALL_SIZE);
  localparam logic [9:0] V_LIM = 10'(V_MAX - BALL_SIZE);
  localparam logic [9:0] STEP  = 10'(SPEED);
  localparam logic [9:0] H0    = 10'(H_INIT);
  localparam logic [9:0] V0    = 10'(V_INIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_MOVE  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t        st;
  logic          vsync_d;
  logic          tick;
  logic          h_dir;
  logic          v_dir;
  logic [CW-1:0] serve_cnt;
  logic [10:0]   h_nx;
  logic [10:0]   v_nx;

  assign tick  = vsync & ~vsync_d;
  assign state = st;

  // Returns {bounce, next_pos}; compares in 11 bits so pos+STEP cannot wrap.
  function automatic logic [10:0] axis_step(
    input logic [9:0] pos,
    input logic       dir,
    input logic [9:0] lim
  );
    logic [10:0] r;
    if (dir) begin
      if (({1'b0, pos} + {1'b0, STEP}) >= {1'b0, lim})
        r = {1'b1, lim};
      else
        r = {1'b0, pos + STEP};
    end else begin
      if (pos <= STEP)
        r = {1'b1, 10'd0};
      else
        r = {1'b0, pos - STEP};
    end
    return r;
  endfunction

  always_comb begin
    h_nx = axis_step(ball_hpos, h_dir, H_LIM);
    v_nx = axis_step(ball_vpos, v_dir, V_LIM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= S_IDLE;
      ball_hpos <= H0;
      ball_vpos <= V0;
      h_dir     <= 1'b0;
      v_dir     <= 1'b1;
      serve_cnt <= '0;
      hit_h     <= 1'b0;
      hit_v     <= 1'b0;
      vsync_d   <= 1'b0;
    end else begin
      vsync_d <= vsync;
      hit_h   <= 1'b0;
      hit_v   <= 1'b0;
      unique case (st)
        S_IDLE: begin
          ball_hpos <= H0;
          ball_vpos <= V0;
          h_dir     <= 1'b0;
          v_dir     <= 1'b1;
          if (launch) begin
            st        <= S_SERVE;
            serve_cnt <= '0;
          end
        end
        S_SERVE: begin
          if (tick) begin
            if (serve_cnt == CNT_LAST)
              st <= S_MOVE;
            else
              serve_cnt <= serve_cnt + 1'b1;
          end
        end
        S_MOVE: begin
          // launch takes precedence over a same-cycle frame tick
          if (launch) begin
            st <= S_PAUSE;
          end else if (tick) begin
            ball_hpos <= h_nx[9:0];
            ball_vpos <= v_nx[9:0];
            h_dir     <= h_dir ^ h_nx[10];
            v_dir     <= v_dir ^ v_nx[10];
            hit_h     <= h_nx[10];
            hit_v     <= v_nx[10];
          end
        end
        S_PAUSE: begin
          if (launch)
            st <= S_MOVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Randomised frame stimulus checked against a signed-integer
// model of the ball plus directed checks of the key scenarios.
module tb_ball_motion_ctrl;

  localparam int SF   = 60;
  localparam int L_H  = 640 - 4;
  localparam int L_V  = 480 - 4;
  localparam int SP   = 2;
  localparam int MAXC = 90000;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       launch;
  logic [9:0] ball_hpos;
  logic [9:0] ball_vpos;
  logic       hit_h;
  logic       hit_v;
  logic [1:0] state;

  always #5 clk = ~clk;

  ball_motion_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
    .launch    (launch),
    .ball_hpos (ball_hpos),
    .ball_vpos (ball_vpos),
    .hit_h     (hit_h),
    .hit_v     (hit_v),
    .state     (state)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit dut_corner = 0;

  // model: 0 idle, 1 serve, 2 move, 3 pause
  int mx, my, dx, dy, mst, mframes, mticks;
  bit mvd, mhh, mhv, mmoved;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  task automatic axis(inout int p, inout int d,
                      input int lim, output bit hit);
    int n;
    n   = p + d * SP;
    hit = 0;
    if (n >= lim) begin
      n = lim; d = -1; hit = 1;
    end else if (n <= 0) begin
      n = 0; d = 1; hit = 1;
    end
    p = n;
  endtask

  task automatic model(input bit r, input bit vs, input bit ln);
    bit tk;
    mhh    = 0;
    mhv    = 0;
    mmoved = 0;
    if (r) begin
      mst = 0; mx = 64; my = 64; dx = -1; dy = 1;
      mvd = 0; mframes = 0;
      return;
    end
    tk  = vs && !mvd;
    mvd = vs;
    case (mst)
      0: begin
        mx = 64; my = 64; dx = -1; dy = 1;
        if (ln) begin mst = 1; mframes = 0; end
      end
      1: if (tk) begin
        mframes++;
        if (mframes == SF) mst = 2;
      end
      2: begin
        if (ln) mst = 3;
        else if (tk) begin
          axis(mx, dx, L_H, mhh);
          axis(my, dy, L_V, mhv);
          mticks++;
          mmoved = 1;
        end
      end
      default: if (ln) mst = 2;
    endcase
  endtask

  task automatic step(input bit r, input bit vs, input bit ln);
    reset  = r;
    vsync  = vs;
    launch = ln;
    @(posedge clk);
    model(r, vs, ln);
    #1;
    cyc++;
    check("state", 32'(state), 32'(mst));
    check("hpos", 32'(ball_hpos), 32'(mx));
    check("vpos", 32'(ball_vpos), 32'(my));
    check("hit_h", 32'(hit_h), 32'(mhh));
    check("hit_v", 32'(hit_v), 32'(mhv));
    if (hit_h && hit_v) dut_corner = 1;
    if (mmoved) begin
      if (mticks == 32) begin
        check("left_wall_pos", 32'(ball_hpos), 0);
        check("left_wall_hit", 32'(hit_h), 1);
      end
      if (mticks == 33)
        check("left_rebound", 32'(ball_hpos), 2);
      if (mticks == 206) begin
        check("bottom_pos", 32'(ball_vpos), 476);
        check("bottom_hit", 32'(hit_v), 1);
      end
      if (mticks == 207)
        check("bottom_rebound", 32'(ball_vpos), 474);
    end
  endtask

  task automatic frame(input int hi, input int lo, input bit ln);
    step(0, 1, ln);
    for (int i = 1; i < hi; i++) step(0, 1, 0);
    for (int i = 0; i < lo; i++) step(0, 0, 0);
  endtask

  initial begin
    int sh, sv, d;
    mticks = 0;
    mvd    = 0;
    reset  = 1;
    vsync  = 0;
    launch = 0;
    repeat (3) step(1, 0, 0);
    check("rst_state", 32'(state), 0);
    check("rst_hpos", 32'(ball_hpos), 64);
    check("rst_vpos", 32'(ball_vpos), 64);

    repeat (5) frame(2, 2, 0);
    check("idle_state", 32'(state), 0);
    check("idle_hpos", 32'(ball_hpos), 64);

    step(0, 0, 1);
    repeat (SF - 1) frame(2, 2, 0);
    check("serve_wait", 32'(state), 1);
    frame(2, 2, 0);
    check("serve_done", 32'(state), 2);
    check("serve_hpos", 32'(ball_hpos), 64);
    check("serve_vpos", 32'(ball_vpos), 64);
    frame(2, 2, 0);
    check("first_hpos", 32'(ball_hpos), 62);
    check("first_vpos", 32'(ball_vpos), 66);

    // random frame lengths with occasional pause toggles
    while (mticks < 400 && cyc < MAXC) begin
      int hi, lo;
      hi = $urandom_range(1, 3);
      lo = $urandom_range(1, 3);
      for (int i = 0; i < hi + lo; i++)
        step(0, i < hi, $urandom_range(0, 47) == 0);
    end
    if (mst == 3) step(0, 0, 1);

    // run on to the first corner hit (move tick 7346)
    while (mticks < 7350 && cyc < MAXC)
      frame($urandom_range(1, 3), $urandom_range(1, 3), 0);
    check("run_in_budget", 32'(mticks >= 7350), 1);
    check("corner_hit", 32'(dut_corner), 1);

    sh = ball_hpos;
    sv = ball_vpos;
    frame(2, 2, 1);
    check("pause_state", 32'(state), 3);
    check("pause_hpos", 32'(ball_hpos), 32'(sh));
    check("pause_vpos", 32'(ball_vpos), 32'(sv));
    repeat (3) frame(2, 2, 0);
    check("pause_hold_h", 32'(ball_hpos), 32'(sh));
    check("pause_hold_v", 32'(ball_vpos), 32'(sv));
    step(0, 0, 1);
    check("resume_still", 32'(ball_hpos), 32'(sh));
    frame(2, 2, 0);
    check("resume_state", 32'(state), 2);
    d = int'(ball_hpos) - sh;
    check("resume_dh", 32'(d < 0 ? -d : d), 2);
    d = int'(ball_vpos) - sv;
    check("resume_dv", 32'(d < 0 ? -d : d), 2);

    step(0, 0, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    repeat (3) step(0, 1, 0);
    check("rst_hi_state", 32'(state), 0);
    check("rst_hi_hpos", 32'(ball_hpos), 64);
    check("rst_hi_vpos", 32'(ball_vpos), 64);
    step(0, 1, 1);
    repeat (4) step(0, 1, 0);
    repeat (2) step(0, 0, 0);
    repeat (SF - 1) frame(2, 2, 0);
    check("no_stale_tick", 32'(state), 1);
    frame(2, 2, 0);
    check("reserve_done", 32'(state), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
